pipe_ctrl: RTL

//  Consumes hazard-unit requests (StallF/StallD/FlushD/FlushE) and drives the per-stage

---
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage RV32 core: stage enables/clears, per-stage valid bits,
// Execute hold for the iterative mul/div unit with timeout, and saturating stall/flush counters.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_RUN    | normal flow, hazard unit requests pass straight through
//  ST_MDBUSY | mul/div in Execute, whole front end frozen, hazards masked
module pipe_ctrl #(
    parameter int CNTW       = 32,
    parameter int MD_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            FlushE,
    input  logic            MdStartE,
    input  logic            MdDoneE,
    output logic            EnF,
    output logic            EnD,
    output logic            EnE,
    output logic            ClrD,
    output logic            ClrE,
    output logic            ValidD,
    output logic            ValidE,
    output logic            ValidM,
    output logic            ValidW,
    output logic            MdBusy,
    output logic            MdTimeout,
    output logic [CNTW-1:0] StallCycles,
    output logic [CNTW-1:0] FlushCount
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_MDBUSY = 1'b1;

    // Hold timer counts down from MD_TIMEOUT-1; reaching zero without done is the timeout.
    localparam int             MDW     = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [0:0]      state_q, state_d;
    logic [MDW-1:0]  md_cnt_q, md_cnt_d;
    logic            vld_dec_q, vld_dec_d;
    logic            vld_exe_q, vld_exe_d;
    logic            vld_mem_q, vld_mem_d;
    logic            vld_wb_q, vld_wb_d;
    logic            md_timeout_q, md_timeout_d;
    logic [CNTW-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNTW-1:0] flush_count_q, flush_count_d;
    logic            md_busy;

    assign md_busy = (state_q == ST_MDBUSY);

    always_comb begin
        EnF  = 1'b0;
        EnD  = 1'b0;
        EnE  = 1'b0;
        ClrD = 1'b0;
        ClrE = 1'b0;
        if (!md_busy) begin
            EnF  = ~StallF;
            EnD  = ~StallD;
            EnE  = 1'b1;
            ClrD = FlushD;
            ClrE = FlushE;
        end
    end

    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        md_timeout_d = md_timeout_q;
        case (state_q)
            ST_RUN: begin
                // A done in the start cycle is a single-cycle op, no hold needed.
                if (MdStartE && vld_exe_q && !FlushE && !MdDoneE) begin
                    state_d  = ST_MDBUSY;
                    md_cnt_d = MD_LOAD;
                end
            end
            ST_MDBUSY: begin
                if (MdDoneE) begin
                    state_d  = ST_RUN;
                    md_cnt_d = '0;
                end else if (md_cnt_q == '0) begin
                    state_d      = ST_RUN;
                    md_cnt_d     = '0;
                    md_timeout_d = 1'b1;
                end else begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = ST_RUN;
                md_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        vld_dec_d = vld_dec_q;
        if (ClrD)
            vld_dec_d = 1'b0;
        else if (EnD)
            vld_dec_d = 1'b1;

        vld_exe_d = vld_exe_q;
        if (ClrE)
            vld_exe_d = 1'b0;
        else if (EnE)
            vld_exe_d = vld_dec_q & ~StallD;

        // Execute is held, so Memory receives bubbles until the result is ready.
        vld_mem_d = (md_busy && !MdDoneE) ? 1'b0 : vld_exe_q;
        vld_wb_d  = vld_mem_q;
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!EnF && (stall_cycles_q != CNT_MAX))
            stall_cycles_d = stall_cycles_q + 1'b1;

        flush_count_d = flush_count_q;
        if (ClrE && (flush_count_q != CNT_MAX))
            flush_count_d = flush_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            md_cnt_q       <= '0;
            vld_dec_q      <= 1'b0;
            vld_exe_q      <= 1'b0;
            vld_mem_q      <= 1'b0;
            vld_wb_q       <= 1'b0;
            md_timeout_q   <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            md_cnt_q       <= md_cnt_d;
            vld_dec_q      <= vld_dec_d;
            vld_exe_q      <= vld_exe_d;
            vld_mem_q      <= vld_mem_d;
            vld_wb_q       <= vld_wb_d;
            md_timeout_q   <= md_timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign ValidD      = vld_dec_q;
    assign ValidE      = vld_exe_q;
    assign ValidM      = vld_mem_q;
    assign ValidW      = vld_wb_q;
    assign MdBusy      = md_busy;
    assign MdTimeout   = md_timeout_q;
    assign StallCycles = stall_cycles_q;
    assign FlushCount  = flush_count_q;

endmodule
